// File: rtl/inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq
// Streams the 16 bytes of a 128-bit AES state into a single-port inverse S-box
// ROM (one address per cycle) and reassembles the returned bytes into the
// substituted state.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   Start, State_In   request and state to substitute (byte 0 = MSB)
//   Busy              high from the cycle after accept until the last capture
//   Done              one-cycle pulse, State_Out valid from this cycle
//   State_Out         substituted state, held until the next completion
//   ROM_Read_Enable   ROM read strobe
//   ROM_Read_Address  ROM read address
//   ROM_Read_Data     ROM read data, valid ROM_LATENCY cycles after the strobe
// -----------------------------------------------------------------------------
module inv_sub_bytes_seq #(
   parameter int unsigned ROM_LATENCY = 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         Start,
   input  logic [127:0] State_In,
   output logic         Busy,
   output logic         Done,
   output logic [127:0] State_Out,
   output logic         ROM_Read_Enable,
   output logic [7:0]   ROM_Read_Address,
   input  logic [7:0]   ROM_Read_Data
);

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned N_BYTES = 16;
   localparam int unsigned STATE_W = BYTE_W * N_BYTES;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                                r_state;
   state_t                                w_state_nxt;
   logic [CNT_W-1:0]                      r_cnt;
   logic [STATE_W-1:0]                    r_buf;
   logic [STATE_W-1:0]                    r_res;
   logic [ROM_LATENCY-1:0]                r_vld;
   logic [ROM_LATENCY-1:0][CNT_W-1:0]     r_idx;
   logic                                  r_busy;
   logic                                  r_done;
   logic [STATE_W-1:0]                    r_out;
   logic                                  r_en;
   logic [BYTE_W-1:0]                     r_addr;

   logic                                  w_accept;
   logic                                  w_issue;
   logic                                  w_issue_last;
   logic [CNT_W-1:0]                      w_cnt_nxt;
   logic                                  w_cap_vld;
   logic [CNT_W-1:0]                      w_cap_idx;
   logic                                  w_cap_last;
   logic [BYTE_W-1:0]                     w_next_byte;
   logic [STATE_W-1:0]                    w_res_nxt;

   assign w_accept     = (r_state == S_IDLE) && Start;
   assign w_issue      = (r_state == S_ISSUE);
   assign w_cnt_nxt    = r_cnt + CNT_W'(1);
   // 4-bit wrap back to zero marks the sixteenth issue
   assign w_issue_last = w_issue && (w_cnt_nxt == '0);
   assign w_cap_vld    = r_vld[ROM_LATENCY-1];
   assign w_cap_idx    = r_idx[ROM_LATENCY-1];
   assign w_cap_last   = w_cap_vld && (w_cap_idx == CNT_W'(N_BYTES - 1));

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (Start)        w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_issue_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_cap_last)   w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   // Buffered byte addressed by the incremented counter (next address)
   always_comb begin
      w_next_byte = '0;
      for (int unsigned b = 0; b < N_BYTES; b++) begin
         if (w_cnt_nxt == CNT_W'(b))
            w_next_byte = r_buf[BYTE_W*(N_BYTES-1-b) +: BYTE_W];
      end
   end

   // Result with the currently returning byte merged in; ROM data is only
   // taken when the capture pipeline says it belongs to an issued read
   always_comb begin
      w_res_nxt = r_res;
      for (int unsigned b = 0; b < N_BYTES; b++) begin
         if (w_cap_vld && (w_cap_idx == CNT_W'(b)))
            w_res_nxt[BYTE_W*(N_BYTES-1-b) +: BYTE_W] = ROM_Read_Data;
      end
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Issue side: input buffer, counter, registered ROM strobe/address
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_buf  <= '0;
         r_cnt  <= '0;
         r_en   <= 1'b0;
         r_addr <= '0;
      end else begin
         r_en <= (w_state_nxt == S_ISSUE);
         if (w_accept) begin
            r_buf  <= State_In;
            r_cnt  <= '0;
            r_addr <= State_In[STATE_W-1 -: BYTE_W];
         end else if (w_issue) begin
            r_cnt <= w_cnt_nxt;
            if (!w_issue_last) r_addr <= w_next_byte;
         end
      end
   end

   // Capture pipeline: one valid bit plus byte index per issued read
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_vld <= '0;
         r_idx <= '0;
      end else begin
         r_vld[0] <= w_issue;
         r_idx[0] <= r_cnt;
         for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_idx[i] <= r_idx[i-1];
         end
      end
   end

   // Result assembly and completion
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_res  <= '0;
         r_out  <= '0;
         r_done <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_res  <= w_res_nxt;
         r_done <= w_cap_last;
         if (w_cap_last) r_out <= w_res_nxt;
         if (w_accept)        r_busy <= 1'b1;
         else if (w_cap_last) r_busy <= 1'b0;
      end
   end

   assign Busy             = r_busy;
   assign Done             = r_done;
   assign State_Out        = r_out;
   assign ROM_Read_Enable  = r_en;
   assign ROM_Read_Address = r_addr;

endmodule
